// File: rtl/stopwatch_control_pkg.sv
// Package for the stopwatch control unit.
// Holds the state codes, the control word for each state and the positions
// of the control word fields used by the datapath.
package stopwatch_pkg;

    localparam int CW_W = 6;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_STOP    = 3'd1,
        S_RUN     = 3'd2,
        S_INC     = 3'd3,
        S_R2LR    = 3'd4,
        S_LAPRUN  = 3'd5,
        S_LAPINC  = 3'd6,
        S_LAPSTOP = 3'd7
    } state_t;

    // Control word field positions
    localparam int CW_MUX_BIT    = 5;   // 0 = counters, 1 = lap register
    localparam int CW_LAP_LD_BIT = 4;   // load lap register
    localparam int CW_CLR_BIT    = 3;   // mod-10 counters sync reset
    localparam int CW_EN_BIT     = 2;   // mod-10 counters enable
    localparam int CW_TMODE_LSB  = 0;   // tenth counter mode [1:0]

    // Control word per state
    localparam logic [CW_W-1:0] CW_RESET   = 6'b001011;
    localparam logic [CW_W-1:0] CW_STOP    = 6'b000000;
    localparam logic [CW_W-1:0] CW_RUN     = 6'b000010;
    localparam logic [CW_W-1:0] CW_INC     = 6'b000111;
    localparam logic [CW_W-1:0] CW_R2LR    = 6'b010000;
    localparam logic [CW_W-1:0] CW_LAPRUN  = 6'b100010;
    localparam logic [CW_W-1:0] CW_LAPINC  = 6'b100111;
    localparam logic [CW_W-1:0] CW_LAPSTOP = 6'b100000;

endpackage

// File: rtl/stopwatch_control_if.sv
// Interface between the stopwatch control unit and its surroundings.
//   btn_start/btn_lap/btn_clear : raw buttons, active-high, asynchronous
//   tenth                       : datapath tenth-counter terminal count
//   cw                          : control word to the datapath
//   state_o                     : current state code for debug/LEDs
// master drives buttons and tenth; slave is the control unit.
interface stopwatch_control_if;
    import stopwatch_pkg::*;

    logic            btn_start;
    logic            btn_lap;
    logic            btn_clear;
    logic            tenth;
    logic [CW_W-1:0] cw;
    logic [2:0]      state_o;

    modport master (
        output btn_start, btn_lap, btn_clear, tenth,
        input  cw, state_o
    );

    modport slave (
        input  btn_start, btn_lap, btn_clear, tenth,
        output cw, state_o
    );
endinterface

// File: rtl/stopwatch_control_button_conditioner.sv
// Button conditioner: SYNC_STAGES-flop synchroniser followed by a rising-edge
// detector. rise is high for exactly one cycle per press, however long the
// button is held.
//   clk, resetn : clock, asynchronous active-low reset
//   raw         : asynchronous button input
//   rise        : single-cycle pulse on a synchronised rising edge
module button_conditioner #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control unit: Moore FSM that turns button events and the datapath
// tenth status into the control word cw.
//   clk, resetn : clock, asynchronous active-low reset
//   sw (slave)  : buttons, tenth in; cw, state_o out
//
//   state   | meaning
//   RESET   | clear counters and load tenth counter (one cycle)
//   STOP    | idle, counters held
//   RUN     | tenth counter counting down
//   INC     | tenth terminal count: reload and bump mod-10 counters
//   R2LR    | capture counters into lap register (one cycle)
//   LAPRUN  | running, display shows lap register
//   LAPINC  | as INC while showing lap register
//   LAPSTOP | stopped, display shows lap register
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int CW_WIDTH    = CW_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    stopwatch_control_if.slave   sw
);
    state_t state_q, state_d;
    logic   start_rise, lap_rise, clear_rise;
    logic   start_p, lap_p, clear_p;
    logic   start_ev, lap_ev, clear_ev;
    logic   take_start, take_lap, take_clear;
    logic [CW_WIDTH-1:0] cw_word;

    button_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_start (
        .clk(clk), .resetn(resetn), .raw(sw.btn_start), .rise(start_rise));
    button_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
        .clk(clk), .resetn(resetn), .raw(sw.btn_lap), .rise(lap_rise));
    button_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
        .clk(clk), .resetn(resetn), .raw(sw.btn_clear), .rise(clear_rise));

    // A fresh edge is usable in the cycle it is detected.
    assign start_ev = start_rise | start_p;
    assign lap_ev   = lap_rise   | lap_p;
    assign clear_ev = clear_rise | clear_p;

    // An event stays pending until taken (consumed or discarded).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_p <= 1'b0;
            lap_p   <= 1'b0;
            clear_p <= 1'b0;
        end else begin
            start_p <= start_ev & ~take_start;
            lap_p   <= lap_ev   & ~take_lap;
            clear_p <= clear_ev & ~take_clear;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_RESET;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        take_start = 1'b0;
        take_lap   = 1'b0;
        // Clear is acted on in STOP and thrown away everywhere else, so it
        // never waits for a later state.
        take_clear = 1'b1;
        case (state_q)
            S_RESET: state_d = S_STOP;
            S_STOP: begin
                take_lap = 1'b1;
                if (clear_ev) begin
                    state_d = S_RESET;
                end else if (start_ev) begin
                    state_d    = S_RUN;
                    take_start = 1'b1;
                end
            end
            S_RUN: begin
                if (sw.tenth) begin
                    state_d = S_INC;
                end else if (start_ev) begin
                    state_d    = S_STOP;
                    take_start = 1'b1;
                end else if (lap_ev) begin
                    state_d  = S_R2LR;
                    take_lap = 1'b1;
                end
            end
            S_INC:  state_d = S_RUN;
            S_R2LR: state_d = S_LAPRUN;
            S_LAPRUN: begin
                if (sw.tenth) begin
                    state_d = S_LAPINC;
                end else if (start_ev) begin
                    state_d    = S_LAPSTOP;
                    take_start = 1'b1;
                end else if (lap_ev) begin
                    state_d  = S_RUN;
                    take_lap = 1'b1;
                end
            end
            S_LAPINC: state_d = S_LAPRUN;
            S_LAPSTOP: begin
                if (start_ev) begin
                    state_d    = S_LAPRUN;
                    take_start = 1'b1;
                end else if (lap_ev) begin
                    state_d  = S_STOP;
                    take_lap = 1'b1;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        cw_word = CW_RESET;
        case (state_q)
            S_RESET:   cw_word = CW_RESET;
            S_STOP:    cw_word = CW_STOP;
            S_RUN:     cw_word = CW_RUN;
            S_INC:     cw_word = CW_INC;
            S_R2LR:    cw_word = CW_R2LR;
            S_LAPRUN:  cw_word = CW_LAPRUN;
            S_LAPINC:  cw_word = CW_LAPINC;
            S_LAPSTOP: cw_word = CW_LAPSTOP;
            default:   cw_word = CW_RESET;
        endcase
    end

    assign sw.cw      = cw_word;
    assign sw.state_o = state_q;
endmodule
